fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-flow controller for the 9-bit single-issue core. Owns the program counter and
//  sequences it from Start to Done. It applies jump/branch redirects from the control
//  decoder, and stalls on data-memory accesses until the memory handshake completes.
//  It sits between the control decoder / jump LUT and the instruction ROM, and gates
//  register-file and data-memory side effects so each instruction commits exactly once.
// PARAMETERS
//  PC_W        10      program counter width; instruction ROM depth = 2**PC_W
//  CNT_W       16      width of the retired-instruction and cycle counters
//  MAX_CYCLES  16'hFFFF  watchdog limit of RUN+MEM_WAIT cycles before forced Done
// PORTS
//  Clk         in   1      single clock; all state changes on posedge
//  Reset       in   1      synchronous, active-high
//  Start       in   1      level; high = hold in IDLE and load PC; falling edge = begin run
//  start_addr  in   PC_W   PC value loaded while Start is high
//  jump_en     in   1      decoder: unconditional jump this instruction
//  branch_en   in   1      decoder: taken branch this instruction (already ANDed with ZERO)
//  lut_target  in   PC_W   absolute redirect target from the jump LUT
//  ReadMem     in   1      decoder: current instruction is a load
//  WriteMem    in   1      decoder: current instruction is a store
//  write_en    in   1      decoder: current instruction writes the register file
//  halt        in   1      decoder: current instruction is the halt opcode
//  mem_ready   in   1      data memory: access complete (sampled only in MEM_WAIT)
//  ProgCtr     out  PC_W   current PC, drives instruction ROM address
//  reg_we      out  1      gated register-file write enable
//  mem_rd      out  1      gated data-memory read strobe
//  mem_wr      out  1      gated data-memory write strobe
//  retire      out  1      one-cycle pulse when an instruction commits
//  Done        out  1      program finished (halt or watchdog); held until Start
//  timeout     out  1      Done was caused by the watchdog
//  instr_cnt   out  CNT_W  retired-instruction count, saturating
// BEHAVIOUR
//  Reset: state=IDLE, ProgCtr=0, Done=0, timeout=0, instr_cnt=0, cycle counter=0.
//   All gated outputs are 0. Reset mid-run aborts with no commit that cycle.
//  States: IDLE, RUN, MEM_WAIT, DONE (enum in definitions package).
//  IDLE: while Start=1, ProgCtr<=start_addr and counters clear; Start=0 -> RUN.
//  RUN: the instruction at ProgCtr is decoded combinationally. Handling, in priority order:
//   - halt=1 -> DONE; retire=1; no reg/mem strobes; PC unchanged.
//   - ReadMem|WriteMem -> mem_rd/mem_wr asserted combinationally; go to MEM_WAIT; PC held.
//   - otherwise commit this cycle: retire=1; reg_we=write_en.
//     Next PC: jump_en -> lut_target; else branch_en -> lut_target; else ProgCtr+1.
//     jump_en has priority over branch_en if both are set.
//  MEM_WAIT: hold mem_rd/mem_wr asserted and ProgCtr stable.
//   - On mem_ready=1: commit (retire=1, reg_we=write_en for loads), ProgCtr<=ProgCtr+1, go to RUN.
//   - Memory ops never redirect. A load commits 1 cycle after mem_ready was already high
//     on entry, so minimum load/store latency is 2 cycles.
//  DONE: Done=1, all strobes 0, PC frozen; Start=1 -> IDLE (Done cleared same edge).
//  Start=1 in RUN or MEM_WAIT: abandon the instruction without committing, then -> IDLE.
//  PC arithmetic is modulo 2**PC_W: PC=2**PC_W-1 plus 1 wraps to 0 with no flag.
//  instr_cnt increments on each retire and saturates at all-ones.
//  Watchdog: the cycle counter increments in RUN and MEM_WAIT. On reaching MAX_CYCLES:
//   next state DONE, timeout=1, no commit that cycle. timeout clears with Done.
//  Strobes reg_we/mem_rd/mem_wr are combinational from state and inputs.
//   They are never high in IDLE or DONE.
// STRUCTURE
//  definitions package: seq_state_t enum {IDLE,RUN,MEM_WAIT,DONE}, PC_W default, kHALT opcode.
//  Single module, with a small next_pc function inline. A pc_next_mux sub-module is
//   allowed but not required. The watchdog counter is inline (no separate module).
// TESTING
//  1. Reset, start_addr=0, Start 1->0. Run 5 plain ALU ops, then halt ->
//     ProgCtr 0..5, retire x6, instr_cnt=6, Done=1 in cycle 7.
//  2. At PC=3, jump_en=1 and lut_target=10'h120 -> next ProgCtr=10'h120.
//     With jump_en and branch_en both 1 -> PC still goes to lut_target, one retire.
//  3. Load at PC=4 with mem_ready low 3 cycles, then high -> 4 stall cycles with mem_rd=1,
//     reg_we pulses once on the mem_ready edge, ProgCtr=5 next.
//  4. start_addr=10'h3FF with a plain op -> ProgCtr wraps to 0.
//     Assert Reset mid MEM_WAIT -> next cycle IDLE, PC=0, no retire.
//  5. MAX_CYCLES=20 with a tight jump-to-self loop -> Done=1 and timeout=1 after 20 cycles.
//     Start=1 then clears both flags.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and default widths.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

  localparam int PC_W_DEF  = 10;
  localparam int CNT_W_DEF = 16;

  // Halt opcode of the 9-bit ISA, decoded upstream into the halt input.
  localparam logic [8:0] kHALT = 9'h1FF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder/memory-side signal bundle of the fetch sequencer; slave is the sequencer itself.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  // mem_rd/mem_wr stay high from the issuing RUN cycle until the cycle mem_ready is
  // seen in MEM_WAIT; that cycle completes the access and no other handshake exists.
  logic             Start;
  logic [PC_W-1:0]  start_addr;
  logic             jump_en;
  logic             branch_en;
  logic [PC_W-1:0]  lut_target;
  logic             ReadMem;
  logic             WriteMem;
  logic             write_en;
  logic             halt;
  logic             mem_ready;
  logic [PC_W-1:0]  ProgCtr;
  logic             reg_we;
  logic             mem_rd;
  logic             mem_wr;
  logic             retire;
  logic             Done;
  logic             timeout;
  logic [CNT_W-1:0] instr_cnt;
  seq_state_t       state;

  modport master (
    output Start, start_addr, jump_en, branch_en, lut_target,
           ReadMem, WriteMem, write_en, halt, mem_ready,
    input  ProgCtr, reg_we, mem_rd, mem_wr, retire, Done, timeout, instr_cnt, state
  );

  modport slave (
    input  Start, start_addr, jump_en, branch_en, lut_target,
           ReadMem, WriteMem, write_en, halt, mem_ready,
    output ProgCtr, reg_we, mem_rd, mem_wr, retire, Done, timeout, instr_cnt, state
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Program-flow controller: owns the PC, applies redirects, stalls on data memory and
// gates side effects so every instruction commits exactly once.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               PC_W       = PC_W_DEF,
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_CYCLES = '1
) (
  input logic             Clk,
  input logic             Reset,
  fetch_sequencer_if.slave bus
);

  seq_state_t       state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             timeout_q;

  logic active, wd_hit, live, mem_op;
  logic retire_c, reg_we_c, mem_rd_c, mem_wr_c;

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] cur,
                                               input logic            jump,
                                               input logic            branch,
                                               input logic [PC_W-1:0] target);
    if (jump || branch) return target;
    return cur + 1'b1;
  endfunction

  assign active = (state == RUN) || (state == MEM_WAIT);
  assign wd_hit = active && (cycle_cnt == MAX_CYCLES - 1'b1);
  // Reset, Start and the watchdog all abandon the current instruction uncommitted.
  assign live   = active && !Reset && !bus.Start && !wd_hit;
  assign mem_op = bus.ReadMem || bus.WriteMem;

  always_comb begin
    retire_c = 1'b0;
    reg_we_c = 1'b0;
    mem_rd_c = 1'b0;
    mem_wr_c = 1'b0;
    if (live) begin
      if (state == RUN) begin
        if (bus.halt) begin
          retire_c = 1'b1;
        end else if (mem_op) begin
          mem_rd_c = bus.ReadMem;
          mem_wr_c = bus.WriteMem;
        end else begin
          retire_c = 1'b1;
          reg_we_c = bus.write_en;
        end
      end else begin
        mem_rd_c = bus.ReadMem;
        mem_wr_c = bus.WriteMem;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          reg_we_c = bus.write_en && bus.ReadMem;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pc        <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            pc        <= bus.start_addr;
            cycle_cnt <= '0;
            instr_cnt <= '0;
          end else begin
            state <= RUN;
          end
        end
        RUN, MEM_WAIT: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (bus.Start) begin
            state <= IDLE;
          end else if (wd_hit) begin
            state     <= DONE;
            timeout_q <= 1'b1;
          end else if (state == RUN) begin
            if (bus.halt)      state <= DONE;
            else if (mem_op)   state <= MEM_WAIT;
            else               pc    <= next_pc(pc, bus.jump_en, bus.branch_en, bus.lut_target);
          end else if (bus.mem_ready) begin
            pc    <= pc + 1'b1;
            state <= RUN;
          end
        end
        DONE: begin
          if (bus.Start) begin
            state     <= IDLE;
            timeout_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (retire_c && !(&instr_cnt)) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign bus.ProgCtr   = pc;
  assign bus.reg_we    = reg_we_c;
  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.retire    = retire_c;
  assign bus.Done      = (state == DONE);
  assign bus.timeout   = timeout_q;
  assign bus.instr_cnt = instr_cnt;
  assign bus.state     = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: retire scoreboard plus point checks of PC and flags.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int W     = PC_W + 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(16'd20)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q[$];
  logic sim_end = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_dec;
    bus.jump_en    = 1'b0;
    bus.branch_en  = 1'b0;
    bus.lut_target = '0;
    bus.ReadMem    = 1'b0;
    bus.WriteMem   = 1'b0;
    bus.write_en   = 1'b0;
    bus.halt       = 1'b0;
    bus.mem_ready  = 1'b0;
  endtask

  // Expected retire record: {PC, reg_we, mem_rd, mem_wr}
  task automatic expect_retire(input logic [PC_W-1:0] pc, input logic we,
                               input logic rd, input logic wr);
    exp_q.push_back({pc, we, rd, wr});
  endtask

  // Hold Start two cycles (abandon anything in flight, load PC), then release into RUN.
  task automatic start_run(input logic [PC_W-1:0] addr);
    bus.Start      = 1'b1;
    bus.start_addr = addr;
    clr_dec();
    tick();
    tick();
    bus.Start = 1'b0;
    tick();
    check("run_state", 32'(bus.state), 32'(RUN));
    check("run_pc", 32'(bus.ProgCtr), 32'(addr));
  endtask

  // Monitor: every retire must match the head of the expected queue; no strobes when idle.
  always @(negedge Clk) begin
    if (!sim_end && !Reset) begin
      if (bus.retire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 32'(bus.ProgCtr), 32'h0000_FFFF);
        end else begin
          check("retire", 32'({bus.ProgCtr, bus.reg_we, bus.mem_rd, bus.mem_wr}),
                32'(exp_q.pop_front()));
        end
      end
      if (bus.state == IDLE || bus.state == DONE)
        check("idle_strobes", 32'({bus.retire, bus.reg_we, bus.mem_rd, bus.mem_wr}), 32'h0);
    end
  end

  initial begin
    bus.Start      = 1'b0;
    bus.start_addr = '0;
    clr_dec();

    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    check("rst_state", 32'(bus.state), 32'(IDLE));
    check("rst_pc", 32'(bus.ProgCtr), 32'h0);
    check("rst_done", 32'(bus.Done), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    check("rst_cnt", 32'(bus.instr_cnt), 32'h0);
    check("rst_strobes", 32'({bus.retire, bus.reg_we, bus.mem_rd, bus.mem_wr}), 32'h0);
    bus.Start = 1'b1;
    Reset = 1'b0;

    // 1: five ALU ops then halt
    start_run(10'h000);
    for (int i = 0; i < 5; i++) begin
      bus.write_en = i[0];
      expect_retire(10'(i), i[0], 1'b0, 1'b0);
      tick();
    end
    bus.write_en = 1'b0;
    bus.halt = 1'b1;
    expect_retire(10'h005, 1'b0, 1'b0, 1'b0);
    tick();
    check("t1_done", 32'(bus.Done), 32'h1);
    check("t1_timeout", 32'(bus.timeout), 32'h0);
    check("t1_cnt", 32'(bus.instr_cnt), 32'd6);
    check("t1_pc", 32'(bus.ProgCtr), 32'h005);
    tick();
    check("t1_done_hold", 32'(bus.Done), 32'h1);
    check("t1_pc_hold", 32'(bus.ProgCtr), 32'h005);

    // 2: jump, jump+branch, branch, fall-through
    start_run(10'h003);
    bus.jump_en = 1'b1;
    bus.write_en = 1'b1;
    bus.lut_target = 10'h120;
    expect_retire(10'h003, 1'b1, 1'b0, 1'b0);
    tick();
    check("t2_jump", 32'(bus.ProgCtr), 32'h120);
    bus.write_en = 1'b0;
    bus.branch_en = 1'b1;
    bus.lut_target = 10'h055;
    expect_retire(10'h120, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_jump_branch", 32'(bus.ProgCtr), 32'h055);
    bus.jump_en = 1'b0;
    bus.lut_target = 10'h200;
    expect_retire(10'h055, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_branch", 32'(bus.ProgCtr), 32'h200);
    bus.branch_en = 1'b0;
    expect_retire(10'h200, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_plain", 32'(bus.ProgCtr), 32'h201);
    check("t2_cnt", 32'(bus.instr_cnt), 32'd4);

    // 3: load with three slow stall cycles, then a store with mem_ready already high
    start_run(10'h004);
    bus.ReadMem = 1'b1;
    bus.write_en = 1'b1;
    tick();
    check("t3_wait_state", 32'(bus.state), 32'(MEM_WAIT));
    for (int i = 0; i < 3; i++) begin
      check("t3_stall", 32'({bus.ProgCtr, bus.mem_rd, bus.reg_we, bus.retire}),
            32'({10'h004, 1'b1, 1'b0, 1'b0}));
      tick();
    end
    bus.mem_ready = 1'b1;
    expect_retire(10'h004, 1'b1, 1'b1, 1'b0);
    tick();
    check("t3_load_pc", 32'(bus.ProgCtr), 32'h005);
    check("t3_load_state", 32'(bus.state), 32'(RUN));
    bus.ReadMem = 1'b0;
    bus.write_en = 1'b0;
    bus.WriteMem = 1'b1;
    tick();
    check("t3_store_wait", 32'(bus.state), 32'(MEM_WAIT));
    expect_retire(10'h005, 1'b0, 1'b0, 1'b1);
    tick();
    check("t3_store_pc", 32'(bus.ProgCtr), 32'h006);
    check("t3_cnt", 32'(bus.instr_cnt), 32'd2);

    // 4: PC wrap, then reset in MEM_WAIT
    start_run(10'h3FF);
    expect_retire(10'h3FF, 1'b0, 1'b0, 1'b0);
    tick();
    check("t4_wrap", 32'(bus.ProgCtr), 32'h000);
    bus.ReadMem = 1'b1;
    bus.write_en = 1'b1;
    tick();
    tick();
    check("t4_in_wait", 32'(bus.state), 32'(MEM_WAIT));
    Reset = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    check("t4_rst_state", 32'(bus.state), 32'(IDLE));
    check("t4_rst_pc", 32'(bus.ProgCtr), 32'h000);
    check("t4_rst_cnt", 32'(bus.instr_cnt), 32'h0);
    bus.Start = 1'b1;
    clr_dec();
    Reset = 1'b0;

    // 5: jump-to-self loop runs into the watchdog
    start_run(10'h010);
    bus.jump_en = 1'b1;
    bus.lut_target = 10'h010;
    for (int i = 0; i < 20; i++) begin
      if (i < 19) expect_retire(10'h010, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 18) check("t5_not_yet", 32'(bus.Done), 32'h0);
    end
    check("t5_done", 32'(bus.Done), 32'h1);
    check("t5_timeout", 32'(bus.timeout), 32'h1);
    check("t5_cnt", 32'(bus.instr_cnt), 32'd19);
    clr_dec();
    bus.Start = 1'b1;
    tick();
    check("t5_clr_done", 32'(bus.Done), 32'h0);
    check("t5_clr_timeout", 32'(bus.timeout), 32'h0);
    check("t5_clr_state", 32'(bus.state), 32'(IDLE));
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    sim_end = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
